// File: rtl/hs_fifo_node_pkg.sv
// rtl/hs_fifo_node_pkg.sv - shared handshake constants and width helper for hs_fifo_node
//
// Purpose: the req/ack timing constants of the dataflow handshake and the
// ceil-log2 helper that sizes the pointers and the occupancy counter.
// Ports: none (package).

package hs_fifo_node_pkg;

    // ack_r is a single-cycle pulse.
    localparam int HS_ACK_PULSE_W = 1;
    // req_l is low for at least this many cycles after each accepted word.
    localparam int HS_MIN_REQ_GAP = 1;

    // ceil(log2(value)); 0 for value <= 1.
    function automatic int hs_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// rtl/hs_fifo_mem.sv - slot storage with synchronous write and registered read
//
// Purpose: depth x data_width register array. The read data register is the
// node's dout: it loads only on a read strobe and otherwise holds its value.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears rdata_o only)
//   we_i       - write strobe
//   waddr_i    - write slot index
//   wdata_i    - write data
//   re_i       - read strobe; loads rdata_o from slot raddr_i at the edge
//   raddr_i    - read slot index
//   rdata_o    - registered read data

module hs_fifo_mem #(
    parameter int data_width = 32,
    parameter int depth      = 4,
    parameter int addr_width = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o
);

    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] rdata_q;

    // Slot contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hs_fifo_node.sv
// rtl/hs_fifo_node.sv - elastic req/ack FIFO node between a pulling upstream and polling consumers
//
// Purpose: buffers up to depth words between a producer that answers our
// req_l with ack_l+din and one or more consumers that jointly raise req_r and
// are answered with a one-cycle ack_r plus dout.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (flushes all slots)
//   req_l     - registered upstream request; low while full and for one cycle after each push
//   ack_l     - upstream acknowledge, din valid in the same cycle
//   din       - upstream data
//   req_r     - downstream requests, all bits must be set to pop
//   ack_r     - downstream acknowledge pulse
//   dout      - downstream data, valid while ack_r is high, held otherwise
//   count     - current occupancy 0..depth

module hs_fifo_node
    import hs_fifo_node_pkg::*;
#(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      req_l,
    input  logic                      ack_l,
    input  logic [data_width-1:0]     din,
    input  logic [output_size-1:0]    req_r,
    output logic                      ack_r,
    output logic [data_width-1:0]     dout,
    output logic [hs_clog2(depth):0]  count
);

    localparam int PTR_W = hs_clog2(depth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth);

    logic             req_l_q, req_l_d;
    logic             ack_r_q, ack_r_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic push;
    logic pop;
    logic mem_we;
    logic mem_re;

    // A push needs our own request to be up; ack_l without it is ignored.
    assign push = ack_l & req_l_q;

    // Pop on the registered count, so a word pushed into an empty buffer is
    // only visible to the consumer one edge later (no bypass). ~ack_r_q keeps
    // ack_r a single-cycle pulse even with req_r held high.
    assign pop = (&req_r) & (count_q != '0) & ~ack_r_q;

    // The ack_l of a reset cycle must not land in the array.
    assign mem_we = push & ~rst;
    assign mem_re = pop & ~rst;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ack_r_d  = pop;

        if (push) begin
            // Power-of-two depth: natural wrap of the pointer is mod depth.
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Dropping after every accepted word spaces pushes two cycles apart;
        // comparing against the next count guarantees no ack while full.
        req_l_d = ~push & (count_d < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_l_q  <= 1'b0;
            ack_r_q  <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            req_l_q  <= req_l_d;
            ack_r_q  <= ack_r_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    hs_fifo_mem #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (mem_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (dout)
    );

    assign req_l = req_l_q;
    assign ack_r = ack_r_q;
    assign count = count_q;

endmodule

// File: tb/tb_hs_fifo_node.sv
// tb/tb_hs_fifo_node.sv - scoreboard testbench for hs_fifo_node

module tb_hs_fifo_node;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OS    = 2;

    logic          clk;
    logic          rst;
    logic          req_l;
    logic          ack_l;
    logic [DW-1:0] din;
    logic [OS-1:0] req_r;
    logic          ack_r;
    logic [DW-1:0] dout;
    logic [2:0]    count;

    hs_fifo_node #(
        .data_width  (DW),
        .depth       (DEPTH),
        .output_size (OS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req_l (req_l),
        .ack_l (ack_l),
        .din   (din),
        .req_r (req_r),
        .ack_r (ack_r),
        .dout  (dout),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acks   = 0;
    int max_count = 0;
    bit saw_dead = 1'b0;
    logic [DW-1:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every ack_r pops the scoreboard and compares dout.
    always @(negedge clk) begin
        if (!rst) begin
            if (int'(count) > max_count) max_count = int'(count);
            if (ack_r === 1'b1) begin
                n_acks++;
                if (dout === 32'hDEAD) saw_dead = 1'b1;
                check("ack_r_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    check("dout_order", dout, sb.pop_front());
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic push_word(input logic [DW-1:0] v);
        int t;
        t = 0;
        while (req_l !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            check("push_timeout", 0, 1);
        end else begin
            ack_l = 1'b1;
            din   = v;
            sb.push_back(v);
            @(negedge clk);
            ack_l = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit prod_done;
        rst   = 1'b1;
        ack_l = 1'b0;
        din   = '0;
        req_r = '0;
        repeat (2) @(negedge clk);
        check("rst_req_l", req_l, 0);
        check("rst_ack_r", ack_r, 0);
        check("rst_dout", dout, 0);
        check("rst_count", count, 0);
        rst = 1'b0;

        // Fill with no downstream request.
        for (int i = 0; i < 4; i++) push_word(i);
        check("fill_count", count, 4);
        repeat (5) @(negedge clk);
        check("full_req_l", req_l, 0);
        check("full_no_ack", n_acks, 0);
        check("full_count_hold", count, 4);

        // Drain from full: req_l comes back right after the first pop.
        req_r = 2'b11;
        @(negedge clk);
        check("drain_first_ack", ack_r, 1);
        check("drain_req_l_back", req_l, 1);
        wait_drain("drain_empty");
        check("drain_acks", n_acks, 4);

        // Streaming with random consumer stalls and partial requests.
        base = n_acks;
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5000; i++) begin
                    push_word(i);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    @(negedge clk);
                    if ($urandom_range(0, 9) < 7) req_r = 2'b11;
                    else req_r = 2'($urandom_range(0, 2));
                end
                req_r = 2'b11;
            end
        join
        wait_drain("stream_drain");
        check("stream_acks", n_acks - base, 5000);
        check("stream_count_le_depth", (max_count <= DEPTH), 1);

        // Partial request holds off the pop.
        req_r = 2'b00;
        repeat (3) @(negedge clk);
        push_word(100);
        req_r = 2'b01;
        base = n_acks;
        repeat (10) @(negedge clk);
        check("partial_no_ack", n_acks - base, 0);
        check("partial_count", count, 1);
        req_r = 2'b11;
        repeat (4) @(negedge clk);
        check("partial_one_ack", n_acks - base, 1);
        req_r = 2'b00;
        repeat (2) @(negedge clk);

        // Push into empty with request pending: ack_r two edges later.
        req_r = 2'b11;
        begin
            int t;
            t = 0;
            while (req_l !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("empty_req_l_up", req_l, 1);
        end
        ack_l = 1'b1;
        din   = 7;
        sb.push_back(7);
        @(negedge clk);
        ack_l = 1'b0;
        check("empty_no_bypass", ack_r, 0);
        @(negedge clk);
        check("empty_ack_2edges", ack_r, 1);
        check("empty_dout", dout, 7);
        req_r = 2'b00;
        repeat (2) @(negedge clk);

        // Reset with three words held; the ack_l during reset is dropped.
        push_word(11);
        push_word(12);
        push_word(13);
        check("pre_rst_count", count, 3);
        rst   = 1'b1;
        ack_l = 1'b1;
        din   = 32'hBAD;
        sb.delete();
        @(negedge clk);
        rst   = 1'b0;
        ack_l = 1'b0;
        check("post_rst_count", count, 0);
        check("post_rst_req_l", req_l, 0);
        check("post_rst_ack_r", ack_r, 0);
        req_r = 2'b11;
        push_word(21);
        wait_drain("post_rst_drain");
        req_r = 2'b00;
        repeat (2) @(negedge clk);

        // Spurious ack_l while full must not write.
        for (int i = 30; i < 34; i++) push_word(i);
        check("spur_full_req_l", req_l, 0);
        ack_l = 1'b1;
        din   = 32'hDEAD;
        repeat (3) @(negedge clk);
        ack_l = 1'b0;
        check("spur_count", count, 4);
        base = n_acks;
        req_r = 2'b11;
        wait_drain("spur_drain");
        repeat (6) @(negedge clk);
        check("spur_acks", n_acks - base, 4);
        check("spur_no_dead", saw_dead, 0);
        check("final_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
